// File: rtl/rx_edge_sampler.sv
// Oversampling edge/bit counters with a three-point majority vote around mid-bit.
// Serial input is synchronized; sampled_bit/sample_valid feed the frame checkers.
module rx_edge_sampler #(
    parameter int SYNC_STAGES = 2,
    parameter int PRESCALE_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  cnt_en,
    input  logic                  sampler_en,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [3:0]            bit_cnt,
    output logic                  sampled_bit,
    output logic                  sample_valid
);

    localparam logic [PRESCALE_W-1:0] PS8  = PRESCALE_W'(8);
    localparam logic [PRESCALE_W-1:0] PS16 = PRESCALE_W'(16);
    localparam logic [PRESCALE_W-1:0] PS32 = PRESCALE_W'(32);
    localparam logic [PRESCALE_W-1:0] ONE  = PRESCALE_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;

    logic [PRESCALE_W-1:0]  ps_eff;
    logic [PRESCALE_W-1:0]  ps_last;
    logic [PRESCALE_W-1:0]  win_lo;
    logic [PRESCALE_W-1:0]  win_mid;
    logic [PRESCALE_W-1:0]  win_hi;

    logic [PRESCALE_W-1:0]  edge_q, edge_d;
    logic [3:0]             bit_q, bit_d;
    logic                   s0_q, s0_d;
    logic                   s1_q, s1_d;
    logic                   v0_q, v0_d;
    logic                   v1_q, v1_d;
    logic                   sampled_q, sampled_d;
    logic                   valid_q, valid_d;
    logic                   en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '1;
        end else if (SYNC_STAGES > 1) begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
        end else begin
            sync_q <= {SYNC_STAGES{rx_in}};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        ps_eff = PS8;
        if (prescale == PS16 || prescale == PS32) begin
            ps_eff = prescale;
        end
    end

    assign ps_last = ps_eff - ONE;
    assign win_mid = ps_eff >> 1;
    assign win_lo  = win_mid - ONE;
    assign win_hi  = win_mid + ONE;

    // >= rather than == so a count left above a newly shortened prescale still wraps
    always_comb begin
        edge_d = edge_q;
        bit_d  = bit_q;
        if (!cnt_en) begin
            edge_d = '0;
            bit_d  = '0;
        end else if (edge_q >= ps_last) begin
            edge_d = '0;
            bit_d  = bit_q + 4'd1;
        end else begin
            edge_d = edge_q + ONE;
        end
    end

    assign en = cnt_en & sampler_en;

    // v0/v1 track an unbroken window; the third sample is voted as it is captured
    always_comb begin
        s0_d      = s0_q;
        s1_d      = s1_q;
        v0_d      = v0_q;
        v1_d      = v1_q;
        sampled_d = sampled_q;
        valid_d   = 1'b0;
        if (!en) begin
            v0_d = 1'b0;
            v1_d = 1'b0;
        end else if (edge_q == win_lo) begin
            s0_d = rx_s;
            v0_d = 1'b1;
            v1_d = 1'b0;
        end else if (edge_q == win_mid) begin
            s1_d = rx_s;
            v1_d = v0_q;
            v0_d = 1'b0;
        end else if (edge_q == win_hi) begin
            v0_d = 1'b0;
            v1_d = 1'b0;
            if (v1_q) begin
                valid_d   = 1'b1;
                sampled_d = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_q    <= '0;
            bit_q     <= '0;
            s0_q      <= 1'b1;
            s1_q      <= 1'b1;
            v0_q      <= 1'b0;
            v1_q      <= 1'b0;
            sampled_q <= 1'b1;
            valid_q   <= 1'b0;
        end else begin
            edge_q    <= edge_d;
            bit_q     <= bit_d;
            s0_q      <= s0_d;
            s1_q      <= s1_d;
            v0_q      <= v0_d;
            v1_q      <= v1_d;
            sampled_q <= sampled_d;
            valid_q   <= valid_d;
        end
    end

    assign edge_cnt     = edge_q;
    assign bit_cnt      = bit_q;
    assign sampled_bit  = sampled_q;
    assign sample_valid = valid_q;

endmodule
